// File: rtl/redstone_pkg.sv
// Shared types and constants for the redstone comparator slice.
package redstone_pkg;

  localparam int unsigned STRENGTH_W = 4;
  localparam int unsigned CNT_W      = 4;

  typedef bit [3:0] redstone;

  localparam redstone REDSTONE_MAX = 15;

  typedef enum bit {CMP_COMPARE, CMP_SUBTRACT} cmp_mode_e;

  typedef enum logic {ST_IDLE, ST_PENDING} cmp_state_e;

endpackage

// File: rtl/redstone_comparator_core.sv
// Combinational compare/subtract core.
//   back, side_l, side_r : 4-bit input strengths
//   mode                 : 0 = compare, 1 = subtract
//   target               : strength the front output should settle to
module comparator_core
  import redstone_pkg::*;
(
  input  logic [STRENGTH_W-1:0] back,
  input  logic [STRENGTH_W-1:0] side_l,
  input  logic [STRENGTH_W-1:0] side_r,
  input  logic                  mode,
  output logic [STRENGTH_W-1:0] target
);

  logic [STRENGTH_W-1:0] side;

  // Strongest side input wins; subtract saturates at zero instead of wrapping.
  always_comb begin
    side   = (side_l > side_r) ? side_l : side_r;
    target = '0;
    if (cmp_mode_e'(mode) == CMP_SUBTRACT) begin
      if (back > side) target = back - side;
    end else begin
      if (back >= side) target = back;
    end
  end

endmodule

// File: rtl/redstone_comparator.sv
// Redstone comparator stage with game-tick delay and pulse filtering.
//   clk, rst_n   : clock, async active-low reset
//   tick         : game-tick enable; FSM advances only when 1
//   back/side_*  : 4-bit input strengths
//   mode_toggle  : level input, each rising edge flips the mode
//   out          : registered front output strength
//   mode         : registered current mode (0 compare, 1 subtract)
//   busy         : 1 while a change is pending
module redstone_comparator
  import redstone_pkg::*;
#(
  parameter int unsigned DELAY     = 2,
  parameter bit          INIT_MODE = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick,
  input  logic [STRENGTH_W-1:0] back,
  input  logic [STRENGTH_W-1:0] side_l,
  input  logic [STRENGTH_W-1:0] side_r,
  input  logic                  mode_toggle,
  output logic [STRENGTH_W-1:0] out,
  output logic                  mode,
  output logic                  busy
);

  localparam logic [CNT_W-1:0] DELAY_CNT = CNT_W'(DELAY);

  cmp_state_e            state, state_d;
  logic [STRENGTH_W-1:0] pending, pending_d;
  logic [STRENGTH_W-1:0] out_d;
  logic [CNT_W-1:0]      cnt, cnt_d;
  logic                  mode_d, busy_d;
  logic                  toggle_q;
  logic                  toggle_rise;
  logic [STRENGTH_W-1:0] target;

  // Target always uses the registered mode, so a toggle takes effect one cycle later.
  comparator_core u_core (
    .back   (back),
    .side_l (side_l),
    .side_r (side_r),
    .mode   (mode),
    .target (target)
  );

  assign toggle_rise = mode_toggle & ~toggle_q;

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      out      <= '0;
      pending  <= '0;
      cnt      <= '0;
      mode     <= INIT_MODE;
      busy     <= 1'b0;
      toggle_q <= 1'b0;
    end else begin
      state    <= state_d;
      out      <= out_d;
      pending  <= pending_d;
      cnt      <= cnt_d;
      mode     <= mode_d;
      busy     <= busy_d;
      toggle_q <= mode_toggle;
    end
  end

  // Next-state: a change must hold for DELAY ticks; reverting to out cancels it.
  always_comb begin
    state_d   = state;
    out_d     = out;
    pending_d = pending;
    cnt_d     = cnt;
    mode_d    = mode ^ toggle_rise;
    if (tick) begin
      case (state)
        ST_IDLE: begin
          if (target != out) begin
            pending_d = target;
            cnt_d     = DELAY_CNT;
            state_d   = ST_PENDING;
          end
        end
        ST_PENDING: begin
          if (target == out) begin
            state_d = ST_IDLE;
          end else if (target != pending) begin
            pending_d = target;
            cnt_d     = DELAY_CNT;
          end else if (cnt == CNT_W'(1)) begin
            out_d   = pending;
            state_d = ST_IDLE;
          end else begin
            cnt_d = cnt - CNT_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d == ST_PENDING);
  end

endmodule
